// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, default
// frame marker and inter-byte timeout, plus a helper naming the states in
// which the inter-byte watchdog runs.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         TIMEOUT_DEF   = 50000;

    // The watchdog only guards the inside of a frame.
    function automatic logic timed_state(state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/program_loader_timeout.sv
// Inter-byte idle watchdog.
// Ports:
//   clock   in  rising-edge clock
//   reset   in  asynchronous active-low reset
//   clr     in  restart the idle count (a byte was accepted)
//   en      in  watchdog armed; count held at zero while low
//   expired out high during the TIMEOUT-th consecutive idle cycle
module program_loader_timeout #(
    parameter int TIMEOUT = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of idle cycles already completed, so the edge that
    // ends idle cycle number TIMEOUT sees cnt == TIMEOUT-1.
    assign expired = en && (cnt == LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)             cnt <= '0;
        else if (clr || !en)    cnt <= '0;
        else if (!expired)      cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream writer for the uP program store.
// Frame: SYNC, LEN_HI (low nibble used), LEN_LO, N=len+1 data bytes, checksum
// byte chosen so that (sum of data + checksum) mod 256 == 0.
// Ports:
//   clock, reset         clock / asynchronous active-low reset
//   in_valid, in_byte    byte stream in; in_ready = accept enable (low only in DONE)
//   clear                one-cycle pulse leaving DONE/ERROR back to IDLE
//   prog_we/addr/data    program memory write port, one cycle after each data accept
//   cpu_hold             keeps the uP in reset while a frame is in progress or failed
//   done, error          frame loaded with good checksum / checksum or timeout failure
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         ADDR_W    = 12,
    parameter int         DATA_W    = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_byte,
    output logic              in_ready,
    input  logic              clear,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t            state, state_nx;
    logic              accept, expired, timed;
    logic              done_nx, error_nx, hold_nx;
    logic [ADDR_W-1:0] len, count;
    logic [DATA_W-1:0] sum, sum_next;

    assign in_ready = (state != ST_DONE);
    assign accept   = in_valid && in_ready;
    assign timed    = timed_state(state);
    assign sum_next = sum + in_byte;

    program_loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clr     (accept),
        .en      (timed),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b0;
        end else begin
            state    <= state_nx;
            done     <= done_nx;
            error    <= error_nx;
            cpu_hold <= hold_nx;
        end
    end

    always_comb begin
        state_nx = state;
        done_nx  = done;
        error_nx = error;
        hold_nx  = cpu_hold;
        case (state)
            ST_IDLE: if (accept && in_byte == SYNC_BYTE) begin
                state_nx = ST_LEN_HI;
                hold_nx  = 1'b1;
                done_nx  = 1'b0;
            end
            ST_LEN_HI: if (accept) state_nx = ST_LEN_LO;
            ST_LEN_LO: if (accept) state_nx = ST_DATA;
            // count still holds the index of the byte being accepted
            ST_DATA:   if (accept && count == len) state_nx = ST_CHECK;
            ST_CHECK: if (accept) begin
                if (sum_next == '0) begin
                    state_nx = ST_DONE;
                    done_nx  = 1'b1;
                    hold_nx  = 1'b0;
                end else begin
                    state_nx = ST_ERROR;
                    error_nx = 1'b1;
                end
            end
            ST_DONE:  if (clear) state_nx = ST_IDLE;
            // clear wins over any byte dropped in the same cycle
            ST_ERROR: if (clear) begin
                state_nx = ST_IDLE;
                error_nx = 1'b0;
                hold_nx  = 1'b0;
            end
            default: state_nx = ST_IDLE;
        endcase
        // accept in the same cycle resets the watchdog, so it wins
        if (timed && expired && !accept) begin
            state_nx = ST_ERROR;
            error_nx = 1'b1;
            hold_nx  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len       <= '0;
            count     <= '0;
            sum       <= '0;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
        end else begin
            prog_we <= 1'b0;
            if (accept) begin
                case (state)
                    ST_LEN_HI: len[ADDR_W-1:8] <= in_byte[ADDR_W-9:0];
                    ST_LEN_LO: begin
                        len[7:0] <= in_byte[7:0];
                        count    <= '0;
                        sum      <= '0;
                    end
                    ST_DATA: begin
                        prog_we   <= 1'b1;
                        prog_addr <= count;
                        prog_data <= in_byte;
                        sum       <= sum_next;
                        count     <= count + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
